// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch block.
//   fetch_state_t : run/halt/single-step control states
//   fetch_entry_t : one buffered {pc, instruction} pair
//   INSTR_BYTES   : byte stride between consecutive instructions
package fetch_pkg;

   typedef enum logic [1:0] {
      HALT = 2'd0,
      RUN  = 2'd1,
      STEP = 2'd2
   } fetch_state_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;

   localparam logic [31:0] INSTR_BYTES = 32'd4;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: small fetch buffer holding fetch_entry_t pairs.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   push       : write push_data (accepted when not full, or full with a pop)
//   push_data  : entry to write
//   pop        : remove the head entry (ignored when empty)
//   flush      : discard all entries; takes priority over push
//   full/empty : occupancy flags
//   head       : oldest entry, combinational read
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  fetch_entry_t push_data,
   input  logic         pop,
   input  logic         flush,
   output logic         full,
   output logic         empty,
   output fetch_entry_t head
);

   localparam int PTR_W = $clog2(DEPTH);

   fetch_entry_t     mem [DEPTH];
   logic [PTR_W-1:0] rd_ptr_reg;
   logic [PTR_W-1:0] wr_ptr_reg;
   logic [PTR_W:0]   count_reg;
   logic             do_pop;
   logic             do_push;

   assign full    = (count_reg == (PTR_W+1)'(DEPTH));
   assign empty   = (count_reg == '0);
   // A full buffer can still take a write when the head leaves in the same cycle.
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop) && !flush;
   assign head    = mem[rd_ptr_reg];

   // Payload storage carries no reset; stale words are unreachable once count is 0.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr_reg] <= push_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr_reg <= '0;
         wr_ptr_reg <= '0;
         count_reg  <= '0;
      end else if (flush) begin
         rd_ptr_reg <= '0;
         wr_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (do_push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
         if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
         if (do_push && !do_pop)      count_reg <= count_reg + 1'b1;
         else if (do_pop && !do_push) count_reg <= count_reg - 1'b1;
      end
   end

endmodule

// File: rtl/fetch_controller.sv
// fetch_controller: owns the PC, issues one instruction-memory fetch per
// cycle, buffers {pc, instr} pairs and hands them to IF/ID via valid/ready.
// Supports branch redirect (flush), run/halt/single-step and counts
// accepted instructions.
// Ports:
//   clk, rst           : clock, asynchronous active-high reset
//   imem_addr/imem_instr : instruction memory address out, word in (same cycle)
//   redirect_valid/pc  : taken branch/jump, target (low two bits dropped)
//   run_en, step       : free-run level, single-fetch pulse while halted
//   out_valid/out_ready/out_pc/out_instr/out_pc4 : IF/ID handshake
//   halted             : FSM is in HALT
//   fetch_count        : accepted handshakes, wraps
//   fetch_fault        : (only with FETCH_BOUNDS_CHECK_EN) sticky out-of-range fetch
// Optional feature macro: FETCH_BOUNDS_CHECK_EN
module fetch_controller
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          MEM_WORDS  = 128,
   parameter int          FIFO_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_instr,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   input  logic        run_en,
   input  logic        step,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_pc,
   output logic [31:0] out_instr,
   output logic [31:0] out_pc4,
   output logic        halted,
   output logic [31:0] fetch_count
`ifdef FETCH_BOUNDS_CHECK_EN
   ,
   output logic        fetch_fault
`endif
);

   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || MEM_WORDS < 1) begin : g_param_check
      $error("fetch_controller: FIFO_DEPTH must be a power of two >= 2 and MEM_WORDS >= 1");
   end

   fetch_state_t state_reg;
   fetch_state_t state_next;
   logic [31:0]  pc_reg;
   logic         fetch_en;
   logic         fire_ok;
   logic         fire;
   logic         pop;
   logic         fifo_full;
   logic         fifo_empty;
   fetch_entry_t push_entry;
   fetch_entry_t head_entry;

   assign fetch_en   = (state_reg == RUN) || (state_reg == STEP);
   assign pop        = out_valid && out_ready;
   // A redirect cycle never pushes: the word at pc_reg is on the wrong path.
   assign fire_ok    = fetch_en && (!fifo_full || pop) && !redirect_valid;
   assign push_entry = '{pc: pc_reg, instr: imem_instr};

`ifdef FETCH_BOUNDS_CHECK_EN
   localparam logic [32:0] ADDR_LIMIT = 33'(MEM_WORDS) * 33'd4;
   logic fault_reg;
   logic fault_hit;

   assign fault_hit   = fire_ok && ({1'b0, pc_reg} >= ADDR_LIMIT);
   assign fire        = fire_ok && !fault_hit;
   assign fetch_fault = fault_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)            fault_reg <= 1'b0;
      else if (fault_hit) fault_reg <= 1'b1;
   end
`else
   assign fire = fire_ok;
`endif

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         RUN:     if (!run_en) state_next = HALT;
         HALT:    if (run_en) state_next = RUN;
                  else if (step) state_next = STEP;
         // The step is consumed even if the buffer was full and nothing fired.
         STEP:    state_next = HALT;
         default: state_next = HALT;
      endcase
`ifdef FETCH_BOUNDS_CHECK_EN
      if (fault_reg || fault_hit) state_next = HALT;
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg   <= HALT;
         pc_reg      <= RESET_PC;
         fetch_count <= '0;
      end else begin
         state_reg <= state_next;
         if (redirect_valid) pc_reg <= redirect_pc & ~(INSTR_BYTES - 32'd1);
         else if (fire)      pc_reg <= pc_reg + INSTR_BYTES;
         // An accept in a redirect cycle is still a delivered instruction.
         if (pop) fetch_count <= fetch_count + 32'd1;
      end
   end

   fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (fire),
      .push_data (push_entry),
      .pop       (pop),
      .flush     (redirect_valid),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .head      (head_entry)
   );

   assign imem_addr = pc_reg;
   assign out_valid = !fifo_empty;
   assign out_pc    = fifo_empty ? 32'd0 : head_entry.pc;
   assign out_instr = fifo_empty ? 32'd0 : head_entry.instr;
   assign out_pc4   = fifo_empty ? 32'd0 : head_entry.pc + INSTR_BYTES;
   assign halted    = (state_reg == HALT);

endmodule

// File: tb/tb_fetch_controller.sv
// tb_fetch_controller: directed self-checking bench for fetch_controller
// (default build). Instruction memory is modelled as a fixed function of
// the address so expected words follow from the expected PC.
module tb_fetch_controller;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] imem_addr;
   logic [31:0] imem_instr;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        run_en;
   logic        step;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_pc;
   logic [31:0] out_instr;
   logic [31:0] out_pc4;
   logic        halted;
   logic [31:0] fetch_count;
`ifdef FETCH_BOUNDS_CHECK_EN
   logic        fetch_fault;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   function automatic logic [31:0] instr_of(input logic [31:0] a);
      return {a[15:0], ~a[15:0]};
   endfunction

   assign imem_instr = instr_of(imem_addr);

   fetch_controller dut (
      .clk            (clk),
      .rst            (rst),
      .imem_addr      (imem_addr),
      .imem_instr     (imem_instr),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .run_en         (run_en),
      .step           (step),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_pc         (out_pc),
      .out_instr      (out_instr),
      .out_pc4        (out_pc4),
      .halted         (halted),
      .fetch_count    (fetch_count)
`ifdef FETCH_BOUNDS_CHECK_EN
      ,
      .fetch_fault    (fetch_fault)
`endif
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end else begin
         $display("ok   %s: %h", tag, got);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Reset for one edge, release at posedge+1; the next edge is the first
   // functional clock (HALT -> RUN when run_en is high).
   task automatic do_reset(input logic run, input logic ready);
      rst            = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = 32'd0;
      step           = 1'b0;
      run_en         = run;
      out_ready      = ready;
      tick();
      rst = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst            = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = 32'd0;
      run_en         = 1'b1;
      step           = 1'b0;
      out_ready      = 1'b1;
      #2;
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_count", fetch_count, 32'd0);
      check("rst_addr", imem_addr, 32'd0);
      check("rst_halted", 32'(halted), 32'd1);
      check("rst_out_pc", out_pc, 32'd0);

      // Free run with out_ready high.
      do_reset(1'b1, 1'b1);
      tick();
      check("run_first_halted", 32'(halted), 32'd0);
      check("run_first_valid", 32'(out_valid), 32'd0);
      for (int k = 0; k < 4; k++) begin
         tick();
         check($sformatf("run_out_pc%0d", k), out_pc, 32'(4 * k));
         check($sformatf("run_instr%0d", k), out_instr, instr_of(32'(4 * k)));
         check($sformatf("run_pc4_%0d", k), out_pc4, 32'(4 * k + 4));
         check($sformatf("run_count%0d", k), fetch_count, 32'(k));
         check($sformatf("run_addr%0d", k), imem_addr, 32'(4 * k + 4));
      end

      // Backpressure: buffer fills with 0x0/0x4, address freezes at 0x8.
      do_reset(1'b1, 1'b0);
      tick();
      for (int k = 0; k < 5; k++) begin
         tick();
         if (k >= 1) begin
            check($sformatf("stall_addr%0d", k), imem_addr, 32'h8);
            check($sformatf("stall_pc%0d", k), out_pc, 32'h0);
         end
      end
      out_ready = 1'b1;
      for (int k = 1; k < 4; k++) begin
         tick();
         check($sformatf("drain_pc%0d", k), out_pc, 32'(4 * k));
         check($sformatf("drain_valid%0d", k), 32'(out_valid), 32'd1);
         check($sformatf("drain_count%0d", k), fetch_count, 32'(k));
      end

      // Redirect with two buffered entries and no accept.
      do_reset(1'b1, 1'b0);
      tick(); tick(); tick();
      check("pre_redir_addr", imem_addr, 32'h8);
      redirect_valid = 1'b1;
      redirect_pc    = 32'h43;
      tick();
      redirect_valid = 1'b0;
      check("redir_valid", 32'(out_valid), 32'd0);
      check("redir_addr", imem_addr, 32'h40);
      check("redir_count", fetch_count, 32'd0);
      out_ready = 1'b1;
      tick();
      check("redir_out_pc", out_pc, 32'h40);
      check("redir_instr", out_instr, instr_of(32'h40));
      tick();
      check("redir_out_pc2", out_pc, 32'h44);
      check("redir_count2", fetch_count, 32'd1);
      // Redirect with a same-cycle accept, to the top of the address space.
      redirect_valid = 1'b1;
      redirect_pc    = 32'hFFFF_FFFF;
      tick();
      redirect_valid = 1'b0;
      check("redir_pop_count", fetch_count, 32'd2);
      check("redir_pop_valid", 32'(out_valid), 32'd0);
      check("wrap_addr_hi", imem_addr, 32'hFFFF_FFFC);
      tick();
      check("wrap_out_pc", out_pc, 32'hFFFF_FFFC);
      check("wrap_out_pc4", out_pc4, 32'h0);
      check("wrap_addr", imem_addr, 32'h0);

      // Single step while halted.
      do_reset(1'b0, 1'b1);
      tick();
      check("halt_halted", 32'(halted), 32'd1);
      check("halt_valid", 32'(out_valid), 32'd0);
      for (int i = 0; i < 3; i++) begin
         step = 1'b1;
         tick();
         step = 1'b0;
         check($sformatf("step%0d_in_step", i), 32'(halted), 32'd0);
         tick();
         check($sformatf("step%0d_pc", i), out_pc, 32'(4 * i));
         check($sformatf("step%0d_halted", i), 32'(halted), 32'd1);
         tick();
         check($sformatf("step%0d_count", i), fetch_count, 32'(i + 1));
         check($sformatf("step%0d_empty", i), 32'(out_valid), 32'd0);
         tick();
         check($sformatf("step%0d_addr", i), imem_addr, 32'(4 * i + 4));
      end

      // Asynchronous reset mid-stream with a full buffer.
      do_reset(1'b1, 1'b1);
      tick(); tick(); tick(); tick();
      out_ready = 1'b0;
      tick(); tick();
      check("mid_count", fetch_count, 32'd2);
      check("mid_out_pc", out_pc, 32'h8);
      check("mid_addr", imem_addr, 32'h10);
      rst = 1'b1;
      #2;
      check("async_valid", 32'(out_valid), 32'd0);
      check("async_count", fetch_count, 32'd0);
      check("async_addr", imem_addr, 32'd0);
      check("async_halted", 32'(halted), 32'd1);
      tick();
      rst = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/fetch_controller.md
Name: fetch_controller

Overview:
- Sequences the instruction memory for the pipelined core: owns the PC, issues one fetch address per cycle and buffers {pc, instruction} pairs in a small FIFO.
- Presents those pairs to the IF/ID stage through a valid/ready handshake.
- Handles branch/jump redirects (flush), run/halt/single-step control for board demos, and counts delivered instructions.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- MEM_WORDS, 128, instruction memory depth in words; the fetch address space is MEM_WORDS*4 bytes.
- FIFO_DEPTH, 2, fetch buffer entries; power of two, at least 2.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- imem_addr  out  32  byte address to the instruction memory; equals pc_q.
- imem_instr  in  32  instruction word, combinational read of imem_addr in the same cycle.
- redirect_valid  in  1  branch/jump taken, one-cycle pulse from EX.
- redirect_pc  in  32  target byte address; bits [1:0] are ignored (forced to 0).
- run_en  in  1  level signal; 1 = free-running fetch, 0 = halt.
- step  in  1  one-cycle pulse; while halted, allows exactly one fetch.
- out_valid  out  1  FIFO head is valid.
- out_ready  in  1  IF/ID accepts the head this cycle.
- out_pc  out  32  PC of the head entry.
- out_instr  out  32  instruction of the head entry.
- out_pc4  out  32  out_pc + 4, mod 2^32.
- halted  out  1  1 when the FSM is in HALT.
- fetch_count  out  32  number of accepted handshakes; wraps at 2^32.

Behaviour:
- Reset (async): pc_q = RESET_PC; FIFO empty; out_valid = 0; out_pc/out_instr/out_pc4 = 0 while empty; fetch_count = 0; FSM = HALT if run_en is low at reset release, else RUN on the first clock; halted = 1 during reset.
- FSM states:
  - RUN: fetch_en = 1.
  - HALT: fetch_en = 0.
  - STEP: fetch_en = 1 for exactly one cycle.
- FSM transitions:
  - RUN -> HALT when run_en = 0.
  - HALT -> RUN when run_en = 1.
  - HALT -> STEP on step = 1 while run_en = 0.
  - STEP -> HALT unconditionally after one cycle, even if the FIFO was full (the step is consumed).
  - step while in RUN is ignored.
- Fetch fires in a cycle when fetch_en is 1 AND (FIFO not full OR out_ready pops this cycle) AND redirect_valid is 0.
  - On fire: push {pc_q, imem_instr}, then pc_q <= pc_q + 4.
- Latency: PC to out_valid is 1 cycle. Sustained throughput is 1 instruction/cycle with out_ready held high.
- Handshake: the head is removed when out_valid && out_ready. out_pc/out_instr stay stable while out_valid && !out_ready. Push and pop in the same cycle keep occupancy unchanged.
- Redirect (highest priority):
  - Next cycle: FIFO flushed, out_valid = 0, pc_q = {redirect_pc[31:2], 2'b00}.
  - No push occurs in the redirect cycle.
  - A pop in the same cycle still counts in fetch_count if out_valid && out_ready.
- Redirect while halted: PC updated and FIFO flushed; FSM stays HALT.
- Redirect together with run_en falling edge: both take effect.
- PC wrap: pc_q + 4 wraps mod 2^32. Without the optional feature, the memory sees the raw address.
- halted = (state == HALT), registered.
- Reset mid-operation: all state cleared immediately; no partial entry survives.

Optional Feature:
- Macro FETCH_BOUNDS_CHECK_EN.
- When defined:
  - Adds output fetch_fault (1 bit, reset 0).
  - If a fetch would fire with pc_q >= MEM_WORDS*4: no push, fetch_fault sets (sticky until reset), FSM forced to HALT and held there regardless of run_en/step.
  - Entries already in the FIFO still drain.
- When undefined: no port, no check; addresses pass unchanged.

Decomposition:
- Package fetch_pkg:
  - fetch_state_t enum {HALT, RUN, STEP}.
  - fetch_entry_t packed struct {pc[31:0], instr[31:0]}.
  - Constant INSTR_BYTES = 4.
- Sub-module fetch_fifo (parameter DEPTH, payload fetch_entry_t):
  - Ports: push, pop, flush, full, empty, head.
  - Same-cycle push+pop allowed when full.
  - Flush wins over push.

Test Plan:
- Reset release with run_en=1, out_ready=1 -> imem_addr 0,4,8,...; out_pc sequence 0,4,8 one cycle behind; fetch_count=3 after 3 accepts.
- out_ready=0 for 5 cycles while running -> FIFO fills to 2 entries; imem_addr frozen at 0x8; out_pc holds 0x0; on release, drains 0x0, 0x4, then 0x8 with no gap.
- redirect_valid=1, redirect_pc=0x43 while FIFO holds 2 entries -> next cycle out_valid=0, imem_addr=0x40; following cycle out_pc=0x40; the old entries are never accepted.
- run_en=0, then three step pulses spaced 4 cycles apart -> exactly 3 entries delivered (pc 0x0, 0x4, 0x8); halted=1 between steps; fetch_count=3.
- With FETCH_BOUNDS_CHECK_EN, MEM_WORDS=4, run from 0 -> pcs 0x0–0xC delivered; at pc 0x10 fetch_fault=1, halted=1; raising run_en has no effect until rst.
- Assert rst for 1 cycle mid-stream with a full FIFO -> out_valid=0, fetch_count=0, imem_addr=RESET_PC immediately (asynchronous).
